// File: rtl/seq_priority_encoder.sv
// Registered priority encoder: sticky pending requests granted one per cycle onto a valid/ready code output.
// Define SEQ_PRIORITY_ENCODER_RR_EN for round-robin search; the default build uses fixed lowest-index-first priority.
module seq_priority_encoder #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E,
    input  logic [N-1:0] req,
    output logic [N-1:0] pend,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic         ovf
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] req_in;
    logic [N-1:0] cand;
    logic [N-1:0] gh;
    logic [N-1:0] pend_d;
    logic [W-1:0] g;
    logic [W-1:0] code_d;
    logic         load;
    logic         ovf_d;

`ifdef SEQ_PRIORITY_ENCODER_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    int           idx;
    logic         found;
`endif

    // NOTE: every signal assigned below gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        req_in  = req & {N{E}};
        cand    = pend | req_in;
        load    = (state_q == EMPTY) || out_ready;
        g       = '0;
        gh      = '0;
        state_d = state_q;
        code_d  = out_code;

`ifdef SEQ_PRIORITY_ENCODER_RR_EN
        idx   = 0;
        found = 1'b0;
        ptr_d = ptr_q;
        // Walk N positions starting at ptr, wrapping at N rather than 2^W.
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && cand[idx]) begin
                found = 1'b1;
                g     = W'(idx);
            end
        end
`else
        // Descending scan so the lowest set index is the one left in g.
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) g = W'(i);
        end
`endif

        if (load) begin
            if (|cand) begin
                state_d = FULL;
                code_d  = g;
                gh[g]   = 1'b1;
`ifdef SEQ_PRIORITY_ENCODER_RR_EN
                ptr_d   = (int'(g) == N - 1) ? '0 : W'(int'(g) + 1);
`endif
            end else begin
                state_d = EMPTY;
            end
        end

        // A request arriving on an index already pending (and not granted now) is merged and lost.
        pend_d = cand & ~gh;
        ovf_d  = ovf | (|(req_in & pend & ~gh));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            pend     <= '0;
            out_code <= '0;
            ovf      <= 1'b0;
`ifdef SEQ_PRIORITY_ENCODER_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pend     <= pend_d;
            out_code <= code_d;
            ovf      <= ovf_d;
`ifdef SEQ_PRIORITY_ENCODER_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Self-checking bench for seq_priority_encoder: directed scenarios plus randomized traffic against a set-based model.
module tb_seq_priority_encoder;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         E = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] pend;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_code;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [N-1:0] m_pend;
    bit         m_valid;
    int         m_code;
    bit         m_ovf;
    int         m_ptr;

    seq_priority_encoder #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .E         (E),
        .req       (req),
        .pend      (pend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    wire [N+W+1:0] dut_vec = {pend, out_valid, out_code, ovf};

    function automatic logic [N+W+1:0] exp_vec();
        return {m_pend, m_valid, W'(m_code), m_ovf};
    endfunction

    function automatic int pick(input bit [N-1:0] c);
`ifdef SEQ_PRIORITY_ENCODER_RR_EN
        for (int k = 0; k < N; k++)
            if (c[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int i = 0; i < N; i++)
            if (c[i]) return i;
`endif
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit [N-1:0] rin, cand, gh;
        int g;
        if (!rst_n) begin
            m_pend = '0; m_valid = 0; m_code = 0; m_ovf = 0; m_ptr = 0;
            return;
        end
        rin  = E ? req : '0;
        cand = m_pend | rin;
        gh   = '0;
        if (!m_valid || out_ready) begin
            if (cand != 0) begin
                g       = pick(cand);
                m_valid = 1;
                m_code  = g;
                gh      = 1 << g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        if ((rin & m_pend & ~gh) != 0) m_ovf = 1;
        m_pend = cand & ~gh;
    endtask

    task automatic tick(input logic r, input logic e, input logic [N-1:0] rq, input logic rdy);
        rst_n = r; E = e; req = rq; out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) tick(1'b0, 1'b1, 4'b1111, 1'b1);
        n_checks++;
        if ({pend, out_valid, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_clear: got pend=%b valid=%b ovf=%b, want all 0", pend, out_valid, ovf);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b1, 4'b0000, 1'b1);
            n_checks++;
            if (dut_vec !== exp_vec() || dut_vec !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: got %b want %b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_single();
        tick(1'b1, 1'b1, 4'b0100, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 2'd2 || pend !== '0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_grant: got valid=%b code=%0d pend=%b, want valid=1 code=2 pend=0000", out_valid, out_code, pend);
        end
        tick(1'b1, 1'b1, 4'b0000, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_drain: got %b want %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_multi();
        tick(1'b1, 1'b1, 4'b1011, 1'b1);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL multi_seq[%0d]: got %b want %b", c, dut_vec, exp_vec());
            end
            tick(1'b1, 1'b1, 4'b0000, 1'b1);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_drained: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        int zeros_seen = 0;
        for (int c = 1; c <= 3; c++) begin
            tick(1'b1, 1'b1, 4'b0001, 1'b0);
            n_checks++;
            if (out_valid !== 1'b1 || out_code !== 2'd0 || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %b want %b", c, dut_vec, exp_vec());
            end
            n_checks++;
            if (ovf !== (c == 3)) begin
                n_fail++;
                $display("FAIL bp_ovf[%0d]: got ovf=%b want %0d", c, ovf, (c == 3));
            end
        end
        zeros_seen = 1;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b1, 4'b0000, 1'b1);
            if (out_valid === 1'b1 && out_code === 2'd0) zeros_seen++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL bp_release[%0d]: got %b want %b", c, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (zeros_seen !== 2 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_total: got code0 count=%0d ovf=%b, want 2 and 1", zeros_seen, ovf);
        end
    endtask

    task automatic test_enable();
        for (int c = 0; c < 4; c++) begin
            tick(1'b1, 1'b0, 4'b1111, 1'b1);
            n_checks++;
            if (out_valid !== 1'b0 || pend !== '0 || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL enable_gate[%0d]: got %b want %b", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b0, 1'b0, 4'b0000, 1'b0);
        tick(1'b1, 1'b1, 4'b1111, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL mid_setup: got %b want %b", dut_vec, exp_vec());
        end
        tick(1'b0, 1'b1, 4'b1111, 1'b0);
        n_checks++;
        if (dut_vec !== '0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want all 0", dut_vec);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b0, 4'b0000, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick(1'b1, 1'b1, 4'b1111, 1'b1);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream[%0d]: got %b want %b", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                 N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 4) < 3));
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b want %b", c, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        m_pend = '0; m_valid = 0; m_code = 0; m_ovf = 0; m_ptr = 0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_enable();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
